vga_raster_gen: RTL and testbench

Raster timing generator for the 640x480 @ 60 Hz VGA output path. It produces the `x_coords`/`y_coords` scan position consumed by the pixel-colour blocks (square drawer, pattern blocks). It samples their 4-bit-per-channel colour back one pixel later and drives the DAC pins with blanked RGB plus `hsync`/`vsync`, all in phase. It is the source end of the coordinate/colour interface the pixel generators implement.

---
 rtl/vga_raster_gen.sv | 80 ++++++++
 tb/tb_vga_raster_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_raster_gen.sv
// vga_raster_gen: VGA raster timing generator; scan counters out, colour sampled back one pixel later to DAC pins
// ports: clck/reset_n/pix_en control, red_in/green_in/blue_in colour for current x_coords/y_coords,
//        x_coords/y_coords scan position, hsync/vsync/video_on/red/green/blue/frame_start aligned DAC-side outputs
module vga_raster_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic       clck,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] x_coords,
  output logic [9:0] y_coords,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        hs_q, hs_d, vs_q, vs_d, von_q, von_d, fs_q, fs_d;
  logic [11:0] rgb_q, rgb_d;
  always_comb begin
    x_d   = !pix_en ? x_q : (x_q == H_LAST) ? '0 : x_q + 10'd1;
    y_d   = !(pix_en && x_q == H_LAST) ? y_q : (y_q == V_LAST) ? '0 : y_q + 10'd1;
    von_d = (x_q < H_VIS) && (y_q < V_VIS);
    hs_d  = !((x_q >= HS_BEG) && (x_q < HS_END));
    vs_d  = !((y_q >= VS_BEG) && (y_q < VS_END));
    rgb_d = von_d ? {red_in, green_in, blue_in} : '0;
    fs_d  = (x_q == '0) && (y_q == '0);
  end
  // output stage describes the pixel the counters pointed at before this edge,
  // so every pin lines up with the colour the generators returned for it
  always_ff @(posedge clck or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b0;
      rgb_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (pix_en) begin
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        von_q <= von_d;
        rgb_q <= rgb_d;
        fs_q  <= fs_d;
      end
    end
  end
  assign x_coords           = x_q;
  assign y_coords           = y_q;
  assign hsync              = hs_q;
  assign vsync              = vs_q;
  assign video_on           = von_q;
  assign {red, green, blue} = rgb_q;
  assign frame_start        = fs_q;
endmodule

// File: tb/tb_vga_raster_gen.sv
// tb_vga_raster_gen: randomized bench for vga_raster_gen on a shrunken raster, checked against a pixel-index model
module tb_vga_raster_gen;
  localparam int HA = 16, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  logic       clck = 1'b0;
  logic       reset_n, pix_en;
  logic [3:0] red_in, green_in, blue_in;
  logic [9:0] x_coords, y_coords;
  logic       hsync, vsync, video_on, frame_start;
  logic [3:0] red, green, blue;
  int n_chk = 0, n_fail = 0;
  int mode = 0, mode_p = 0;
  int p = 0, op = -1;
  logic [11:0] col = '0;
  int ox, oy, cyc = 0, mul, hs_fall = -1, vs_fall = -1, fs_rise = -1;
  logic act, e_von, e_hs, e_vs;
  logic hs_p = 1'b1, vs_p = 1'b1, fs_p = 1'b0;
  vga_raster_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clck(clck), .reset_n(reset_n), .pix_en(pix_en),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .x_coords(x_coords), .y_coords(y_coords),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );
  always #5 clck = ~clck;
  task automatic chk(input string name, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, a, e, $time);
    end
  endtask
  // p = linear index of the pixel the counters point at; op = pixel on the pins (-1 = reset)
  always @(posedge clck or negedge reset_n) begin
    if (!reset_n) begin
      p = 0;
      op = -1;
      col = '0;
    end else if (pix_en) begin
      op = p;
      col = {red_in, green_in, blue_in};
      p = (p + 1) % FT;
    end
  end
  always @(posedge clck) begin
    #1;
    act   = op >= 0;
    ox    = act ? op % HT : 0;
    oy    = act ? op / HT : 0;
    e_von = act && ox < HA && oy < VA;
    e_hs  = !(act && ox >= HA + HF && ox < HA + HF + HS);
    e_vs  = !(act && oy >= VA + VF && oy < VA + VF + VS);
    chk("x_coords", int'(x_coords), p % HT);
    chk("y_coords", int'(y_coords), p / HT);
    chk("hsync", int'(hsync), int'(e_hs));
    chk("vsync", int'(vsync), int'(e_vs));
    chk("video_on", int'(video_on), int'(e_von));
    chk("rgb", int'({red, green, blue}), e_von ? int'(col) : 0);
    chk("frame_start", int'(frame_start), int'(act && op == 0));
    cyc++;
    if (mode != mode_p || !reset_n || mode < 1 || mode > 2) begin
      hs_fall = -1;
      vs_fall = -1;
      fs_rise = -1;
    end else begin
      mul = mode;
      if (hs_p && !hsync) begin
        chk("hs_fall_x", int'(x_coords), HA + HF + 1);
        if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, 23 * mul);
        hs_fall = cyc;
      end
      if (!hs_p && hsync && hs_fall >= 0) chk("hs_width", cyc - hs_fall, 3 * mul);
      if (vs_p && !vsync) begin
        chk("vs_fall_xy", int'({y_coords, x_coords}), int'({10'd7, 10'd1}));
        vs_fall = cyc;
      end
      if (!vs_p && vsync && vs_fall >= 0) chk("vs_width", cyc - vs_fall, 46 * mul);
      if (!fs_p && frame_start) begin
        chk("fs_rise_xy", int'({y_coords, x_coords}), 1);
        if (fs_rise >= 0) chk("fs_period", cyc - fs_rise, 253 * mul);
        fs_rise = cyc;
      end
      if (fs_p && !frame_start && fs_rise >= 0) chk("fs_width", cyc - fs_rise, mul);
    end
    hs_p = hsync;
    vs_p = vsync;
    fs_p = frame_start;
    mode_p = mode;
  end
  task automatic run(input int n, input int m);
    repeat (n) begin
      @(negedge clck);
      mode = m;
      pix_en   = m == 1 ? 1'b1 : m == 2 ? ~pix_en : 1'($urandom % 2);
      red_in   = 4'($urandom);
      green_in = 4'($urandom);
      blue_in  = 4'($urandom);
    end
  endtask
  task automatic first_pixel_checks(input string tag);
    @(posedge clck);
    #2;
    chk({tag, "_red"}, int'(red), 15);
    chk({tag, "_green"}, int'(green), 15);
    chk({tag, "_blue"}, int'(blue), 15);
    chk({tag, "_video_on"}, int'(video_on), 1);
    chk({tag, "_frame_start"}, int'(frame_start), 1);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_x"}, int'(x_coords), 1);
    chk({tag, "_y"}, int'(y_coords), 0);
  endtask
  task automatic reset_value_checks(input string tag);
    chk({tag, "_x"}, int'(x_coords), 0);
    chk({tag, "_y"}, int'(y_coords), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_video_on"}, int'(video_on), 0);
    chk({tag, "_rgb"}, int'({red, green, blue}), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask
  initial begin
    int found;
    reset_n = 1'b0;
    pix_en = 1'b0;
    red_in = '0;
    green_in = '0;
    blue_in = '0;
    repeat (3) @(negedge clck);
    reset_value_checks("rst");
    reset_n = 1'b1;
    pix_en = 1'b1;
    red_in = 4'hF;
    green_in = 4'hF;
    blue_in = 4'hF;
    first_pixel_checks("first");
    run(600, 1);
    run(1200, 2);
    run(800, 3);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clck);
      mode = 0;
      pix_en = 1'b1;
      if (x_coords == 10'd10 && y_coords == 10'd4) found = 1;
    end
    chk("reached_10_4", found, 1);
    @(posedge clck);
    #3;
    reset_n = 1'b0;
    #1;
    reset_value_checks("async_rst");
    repeat (2) @(negedge clck);
    reset_n = 1'b1;
    pix_en = 1'b1;
    red_in = 4'hF;
    green_in = 4'hF;
    blue_in = 4'hF;
    first_pixel_checks("rerun");
    run(600, 1);
    @(negedge clck);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
